// File: rtl/y_enhance_frame_seq.sv
// -----------------------------------------------------------------------------
// y_enhance_frame_seq
//
// Frame sequencer for the Y-channel Sobel enhancement pipeline. It takes
// line-complete pixel bursts from an upstream show-ahead FIFO and drives the
// per_frame_* strobes and per_img_Y into the enhancement datapath. Flush lines
// are appended to empty the 3x3 line buffers. The datapath output (post_img_Y)
// is re-aligned with a registered valid strobe, and frame completion is
// reported with a done pulse.
//
// Ports
//   clk, rst          pixel clock; asynchronous active-high reset
//   start, abort      begin one frame (ignored while busy); synchronous abort
//   fifo_level/empty  upstream FIFO occupancy and empty flag
//   fifo_data, fifo_rd  show-ahead head word and pop strobe
//   per_frame_vsync/href/clken, per_img_Y   datapath input side
//   post_img_Y        datapath output
//   post_valid, post_data                   aligned, qualified enhanced pixels
//   busy, done, underflow                   frame status
// -----------------------------------------------------------------------------
module y_enhance_frame_seq #(
   parameter int IMG_HDISP   = 640,
   parameter int IMG_VDISP   = 480,
   parameter int H_BLANK     = 16,
   parameter int VSYNC_LEN   = 4,
   parameter int V_BLANK     = 8,
   parameter int FLUSH_LINES = 1,
   parameter int PIPE_LAT    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [10:0] fifo_level,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_data,
   output logic        fifo_rd,
   output logic        per_frame_vsync,
   output logic        per_frame_href,
   output logic        per_frame_clken,
   output logic [7:0]  per_img_Y,
   input  logic [7:0]  post_img_Y,
   output logic        post_valid,
   output logic [7:0]  post_data,
   output logic        busy,
   output logic        done,
   output logic        underflow
);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBLANK, S_LWAIT, S_LINE, S_HBLANK, S_DRAIN, S_DONE
   } state_t;

   localparam logic [9:0]  HDISP_M1  = 10'(IMG_HDISP - 1);
   localparam logic [9:0]  VSYNC_M1  = 10'(VSYNC_LEN - 1);
   localparam logic [9:0]  VBLANK_M1 = 10'(V_BLANK - 1);
   localparam logic [9:0]  HBLANK_M1 = 10'(H_BLANK - 1);
   localparam logic [10:0] HDISP_LVL = 11'(IMG_HDISP);
   localparam logic [10:0] VDISP_W   = 11'(IMG_VDISP);
   localparam logic [10:0] TOTAL_W   = 11'(IMG_VDISP + FLUSH_LINES);
   localparam logic [10:0] FLUSH_W   = 11'(FLUSH_LINES);

   state_t              state_q, state_d;
   logic [9:0]          h_cnt_q, h_cnt_d;
   logic [9:0]          b_cnt_q, b_cnt_d;
   logic [10:0]         v_cnt_q, v_cnt_d;
   logic [10:0]         o_cnt_q, o_cnt_d;
   logic                underflow_q, underflow_d;
   logic [PIPE_LAT-1:0] href_dly_q, href_dly_d;
   logic                href_prev_q, href_prev_d;
   logic                post_valid_q, post_valid_d;
   logic [7:0]          post_data_q, post_data_d;

   logic active_line;  // current input line carries FIFO pixels (not a flush line)
   logic href_dly;     // per_frame_href delayed to line up with post_img_Y

   assign active_line = (v_cnt_q < VDISP_W);
   assign href_dly    = href_dly_q[PIPE_LAT-1];

   // Datapath-side strobes decode straight from the state register.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      fifo_rd         = 1'b0;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      per_img_Y       = 8'd0;
      busy            = (state_q != S_IDLE) && (state_q != S_DONE);
      done            = (state_q == S_DONE);
      underflow       = underflow_q;
      post_valid      = post_valid_q;
      post_data       = post_data_q;
      case (state_q)
         S_VSYNC: per_frame_vsync = 1'b1;
         S_LINE: begin
            per_frame_href  = 1'b1;
            per_frame_clken = 1'b1;
            if (active_line) begin
               fifo_rd   = 1'b1;
               per_img_Y = fifo_data;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      h_cnt_d     = h_cnt_q;
      b_cnt_d     = b_cnt_q;
      v_cnt_d     = v_cnt_q;
      o_cnt_d     = o_cnt_q;
      underflow_d = underflow_q;
      href_dly_d  = href_dly_q << 1;
      href_dly_d[0] = per_frame_href;
      href_prev_d = href_dly;

      // Output side: each delayed-href falling edge closes one output line;
      // the first FLUSH_LINES output lines are the line-buffer fill and are dropped.
      if (href_prev_q && !href_dly) o_cnt_d = o_cnt_q + 11'd1;
      post_valid_d = href_dly && (o_cnt_q >= FLUSH_W);
      post_data_d  = post_valid_d ? post_img_Y : 8'd0;

      // The pixel is still consumed; the flag just records the violation.
      if (fifo_rd && fifo_empty) underflow_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_VSYNC;
               underflow_d = 1'b0;
               h_cnt_d     = 10'd0;
               b_cnt_d     = 10'd0;
               v_cnt_d     = 11'd0;
               o_cnt_d     = 11'd0;
            end
         end
         S_VSYNC: begin
            if (b_cnt_q == VSYNC_M1) begin
               b_cnt_d = 10'd0;
               state_d = S_VBLANK;
            end else begin
               b_cnt_d = b_cnt_q + 10'd1;
            end
         end
         S_VBLANK: begin
            if (b_cnt_q == VBLANK_M1) begin
               b_cnt_d = 10'd0;
               state_d = S_LWAIT;
            end else begin
               b_cnt_d = b_cnt_q + 10'd1;
            end
         end
         S_LWAIT: begin
            // A whole line must be buffered up front: LINE never stalls.
            if (!active_line || (fifo_level >= HDISP_LVL)) begin
               h_cnt_d = 10'd0;
               state_d = S_LINE;
            end
         end
         S_LINE: begin
            if (h_cnt_q == HDISP_M1) begin
               h_cnt_d = 10'd0;
               b_cnt_d = 10'd0;
               v_cnt_d = v_cnt_q + 11'd1;
               state_d = S_HBLANK;
            end else begin
               h_cnt_d = h_cnt_q + 10'd1;
            end
         end
         S_HBLANK: begin
            if (b_cnt_q == HBLANK_M1) begin
               b_cnt_d = 10'd0;
               state_d = (v_cnt_q < TOTAL_W) ? S_LWAIT : S_DRAIN;
            end else begin
               b_cnt_d = b_cnt_q + 10'd1;
            end
         end
         S_DRAIN: begin
            if (o_cnt_q == TOTAL_W) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d      = S_IDLE;
         h_cnt_d      = 10'd0;
         b_cnt_d      = 10'd0;
         v_cnt_d      = 11'd0;
         o_cnt_d      = 11'd0;
         underflow_d  = 1'b0;
         href_dly_d   = '0;
         href_prev_d  = 1'b0;
         post_valid_d = 1'b0;
         post_data_d  = 8'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         h_cnt_q      <= 10'd0;
         b_cnt_q      <= 10'd0;
         v_cnt_q      <= 11'd0;
         o_cnt_q      <= 11'd0;
         underflow_q  <= 1'b0;
         href_dly_q   <= '0;
         href_prev_q  <= 1'b0;
         post_valid_q <= 1'b0;
         post_data_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         h_cnt_q      <= h_cnt_d;
         b_cnt_q      <= b_cnt_d;
         v_cnt_q      <= v_cnt_d;
         o_cnt_q      <= o_cnt_d;
         underflow_q  <= underflow_d;
         href_dly_q   <= href_dly_d;
         href_prev_q  <= href_prev_d;
         post_valid_q <= post_valid_d;
         post_data_q  <= post_data_d;
      end
   end

endmodule

// File: tb/tb_y_enhance_frame_seq.sv
// -----------------------------------------------------------------------------
// tb_y_enhance_frame_seq
//
// Directed bench for y_enhance_frame_seq with a small frame (8x4, one flush
// line). A 32-byte upstream FIFO holding 0..31 and an identity-xor datapath
// with a 5-cycle latency surround the DUT. Cycle numbers are relative to the
// cycle in which start is presented (T0).
// -----------------------------------------------------------------------------
module tb_y_enhance_frame_seq;

   localparam int HD = 8, VD = 4, HB = 4, VS = 2, VB = 3, FL = 1, PL = 5;

   localparam int M_NORMAL = 0, M_LEVEL = 1, M_UFLOW = 2, M_ABORT = 3,
                  M_XSTART = 4, M_RST = 5;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [10:0] fifo_level;
   logic        fifo_empty;
   logic [7:0]  fifo_data;
   logic        fifo_rd;
   logic        per_frame_vsync, per_frame_href, per_frame_clken;
   logic [7:0]  per_img_Y, post_img_Y, post_data;
   logic        post_valid, busy, done, underflow;

   always #5 clk = ~clk;

   y_enhance_frame_seq #(
      .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB), .VSYNC_LEN(VS),
      .V_BLANK(VB), .FLUSH_LINES(FL), .PIPE_LAT(PL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd), .per_frame_vsync(per_frame_vsync),
      .per_frame_href(per_frame_href), .per_frame_clken(per_frame_clken),
      .per_img_Y(per_img_Y), .post_img_Y(post_img_Y), .post_valid(post_valid),
      .post_data(post_data), .busy(busy), .done(done), .underflow(underflow)
   );

   // Upstream FIFO: 32 bytes, word k holds value k.
   logic [7:0]  rd_ptr;
   logic [10:0] fifo_count;
   logic        fifo_reload, lvl_force, empty_force;

   always @(posedge clk) begin
      if (fifo_reload)  rd_ptr <= 8'd0;
      else if (fifo_rd) rd_ptr <= rd_ptr + 8'd1;
   end

   always_comb begin
      fifo_count = (rd_ptr >= 8'd32) ? 11'd0 : (11'd32 - {3'b000, rd_ptr});
      fifo_level = lvl_force ? 11'd5 : fifo_count;
      fifo_empty = empty_force || (fifo_count == 11'd0);
      fifo_data  = rd_ptr;
   end

   // Datapath stand-in: post_img_Y = per_img_Y ^ 0x5A, PL cycles later.
   logic [7:0] dp [PL];
   always @(posedge clk) begin
      dp[0] <= per_img_Y ^ 8'h5A;
      for (int i = 1; i < PL; i++) dp[i] <= dp[i-1];
   end
   assign post_img_Y = dp[PL-1];

   logic [23:0] outs;
   assign outs = {fifo_rd, per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
                  post_valid, post_data, busy, done, underflow};

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Per-run observations
   int vs_first, vs_cnt, href_first, href_cnt, bursts, href2_first;
   int rd_cnt, rd_first, y_sum, y5_nz;
   int pv_cnt, pv_bursts, pv_first, pd_bad;
   int done_cnt, done_rel, busy_after, busy_rel1, uf_first, uf_at_done, uf_rel1;
   int href_after_rst;
   logic href_prev, pv_prev;

   task automatic run_frame(input int mode, input string name);
      int rel;
      bit fin;
      logic [7:0] exp_pd;
      vs_first = -1; vs_cnt = 0; href_first = -1; href_cnt = 0; bursts = 0;
      href2_first = -1; rd_cnt = 0; rd_first = -1; y_sum = 0; y5_nz = 0;
      pv_cnt = 0; pv_bursts = 0; pv_first = -1; pd_bad = 0;
      done_cnt = 0; done_rel = -1; busy_after = 1; busy_rel1 = 0;
      uf_first = -1; uf_at_done = 0; uf_rel1 = 1; href_after_rst = 0;
      href_prev = 1'b0; pv_prev = 1'b0;

      @(negedge clk); fifo_reload = 1'b1;
      @(negedge clk); fifo_reload = 1'b0;
      lvl_force = (mode == M_LEVEL);
      @(negedge clk); start = 1'b1;   // T0
      rel = 0;
      fin = 1'b0;
      while (!fin && rel < 200) begin
         @(negedge clk);
         rel++;
         start = 1'b0;
         // ---- sample cycle rel ----
         if (rel == 1) begin busy_rel1 = busy; uf_rel1 = underflow; end
         if (per_frame_vsync) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = rel;
         end
         if (per_frame_href) begin
            if (!href_prev) begin
               bursts++;
               if (bursts == 2) href2_first = rel;
            end
            if (href_first < 0) href_first = rel;
            href_cnt++;
            if (bursts == 5 && per_img_Y != 8'd0) y5_nz++;
            if (bursts < 5) y_sum += per_img_Y;
         end
         href_prev = per_frame_href;
         if (fifo_rd) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = rel;
         end
         if (post_valid) begin
            if (!pv_prev) pv_bursts++;
            if (pv_first < 0) pv_first = rel;
            exp_pd = (pv_cnt < 24) ? (8'(pv_cnt + 8) ^ 8'h5A) : 8'h5A;
            if (post_data != exp_pd) pd_bad++;
            pv_cnt++;
         end
         pv_prev = post_valid;
         if (underflow && uf_first < 0) uf_first = rel;
         if (done) begin
            done_cnt++;
            done_rel = rel;
            uf_at_done = underflow;
         end
         if (done_cnt > 0 && rel == done_rel + 1) busy_after = busy;

         // ---- stimulus for the rest of cycle rel ----
         case (mode)
            M_LEVEL:  if (rel == 20) lvl_force = 1'b0;
            M_UFLOW: begin
               if (rel == 9)  empty_force = 1'b1;
               if (rel == 10) empty_force = 1'b0;
            end
            M_ABORT: begin
               if (rel == 39) abort = 1'b1;
               if (rel == 40) begin
                  check({name, "_abort_busy"}, busy, 0);
                  check({name, "_abort_outs"}, outs, 0);
                  abort = 1'b0;
               end
               if (rel == 60) fin = 1'b1;
            end
            M_XSTART: if (rel == 10 || rel == 72) start = 1'b1;
            M_RST: begin
               if (rel == 16) begin
                  check({name, "_busy_pre_rst"}, busy, 1);
                  #2 rst = 1'b1;
                  #1 check({name, "_rst_async_outs"}, outs, 0);
               end
               if (rel == 17) rst = 1'b0;
               if (rel > 17 && per_frame_href) href_after_rst++;
               if (rel == 24) begin
                  check({name, "_idle_busy"}, busy, 0);
                  check({name, "_idle_href"}, href_after_rst, 0);
                  fin = 1'b1;
               end
            end
            default: ;
         endcase
         if (done_cnt > 0 && rel >= done_rel + 2) fin = 1'b1;
      end
      lvl_force = 1'b0;
      empty_force = 1'b0;
      abort = 1'b0;
   endtask

   task automatic check_full_frame(input string name, input int exp_href_first,
                                   input int exp_done_rel);
      check({name, "_busy_t1"},      busy_rel1, 1);
      check({name, "_vsync_first"},  vs_first, 1);
      check({name, "_vsync_len"},    vs_cnt, 2);
      check({name, "_href_first"},   href_first, exp_href_first);
      check({name, "_rd_first"},     rd_first, exp_href_first);
      check({name, "_href_bursts"},  bursts, 5);
      check({name, "_href_cycles"},  href_cnt, 40);
      check({name, "_rd_total"},     rd_cnt, 32);
      check({name, "_y_sum"},        y_sum, 496);
      check({name, "_flush_y_nz"},   y5_nz, 0);
      check({name, "_pv_beats"},     pv_cnt, 32);
      check({name, "_pv_bursts"},    pv_bursts, 4);
      check({name, "_pv_offset"},    pv_first - href2_first, 6);
      check({name, "_pd_bad"},       pd_bad, 0);
      check({name, "_done_pulses"},  done_cnt, 1);
      check({name, "_done_rel"},     done_rel, exp_done_rel);
      check({name, "_busy_after"},   busy_after, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      fifo_reload = 1'b1; lvl_force = 1'b0; empty_force = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", outs, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_outs", outs, 0);

      // Baseline frame
      run_frame(M_NORMAL, "basic");
      check_full_frame("basic", 7, 74);
      check("basic_underflow", uf_first, -1);

      // FIFO level below one line until T20
      run_frame(M_LEVEL, "level");
      check_full_frame("level", 21, 88);

      // fifo_empty forced on the third pixel of line 0
      run_frame(M_UFLOW, "uflow");
      check("uflow_first", uf_first, 10);
      check("uflow_at_done", uf_at_done, 1);
      check("uflow_done_pulses", done_cnt, 1);
      check("uflow_held_idle", underflow, 1);

      // Abort partway through line 2; underflow cleared by this start
      run_frame(M_ABORT, "abort");
      check("abort_uf_cleared", uf_rel1, 0);
      check("abort_rd_before", rd_cnt, 23);
      check("abort_no_done", done_cnt, 0);

      // Replay after abort with stray starts during LINE and DRAIN
      run_frame(M_XSTART, "replay");
      check_full_frame("replay", 7, 74);

      // Reset pulse during HBLANK of line 0
      run_frame(M_RST, "rst");
      check("rst_no_done", done_cnt, 0);

      // Clean frame after the reset pulse
      run_frame(M_NORMAL, "after_rst");
      check_full_frame("after_rst", 7, 74);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
